// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, decode handshake, redirect, halt, error
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [15:0] imem_data,
   output logic [15:0] instr,
   output logic [15:0] pc_plus2,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        halted,
   output logic        err
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      VALID  = 2'd1,
      HALTED = 2'd2,
      ERROR  = 2'd3
   } state_t;

   localparam logic [4:0] HALT_OPCODE = 5'b00000;

   state_t      state;
   logic [15:0] pc;
   logic        is_halt;

   // Request is gated by reset so no fetch is ever issued while reset is held.
   assign imem_req  = (state == FETCH) && rst;
   assign imem_addr = pc;

   // Fetch FSM: redirect outranks both the memory response and decode acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         instr       <= 16'h0000;
         pc_plus2    <= 16'h0000;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
         is_halt     <= 1'b0;
      end else begin
         case (state)
            FETCH, VALID: begin
               if (redirect) begin
                  instr_valid <= 1'b0;
                  if (redirect_pc[0]) begin
                     // Misaligned target: park in ERROR without touching the PC.
                     err   <= 1'b1;
                     state <= ERROR;
                  end else begin
                     pc      <= redirect_pc;
                     is_halt <= 1'b0;
                     state   <= FETCH;
                  end
               end else if (state == FETCH) begin
                  if (imem_rdy) begin
                     instr       <= imem_data;
                     pc_plus2    <= pc + 16'd2;
                     is_halt     <= (imem_data[15:11] == HALT_OPCODE);
                     instr_valid <= 1'b1;
                     state       <= VALID;
                  end
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (is_halt) begin
                     // HALT consumed: PC stays on the HALT word.
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     pc    <= pc + 16'd2;
                     state <= FETCH;
                  end
               end
            end
            HALTED: begin
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end
            default: begin
               instr_valid <= 1'b0;
               err         <= 1'b1;
               halted      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic [15:0] pc_plus2;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halted;
   logic        err;

   int n_checks;
   int n_fail;

   typedef struct {
      logic        redirect;
      logic [15:0] redirect_pc;
      logic        imem_rdy;
      logic [15:0] imem_data;
      logic        instr_ready;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic [15:0] e_pp2;
      logic        e_halted;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdy    (imem_rdy),
      .imem_data   (imem_data),
      .instr       (instr),
      .pc_plus2    (pc_plus2),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halted      (halted),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic req, input logic [15:0] addr,
                             input logic valid, input logic [15:0] ins, input logic [15:0] pp2,
                             input logic hlt, input logic er);
      check({tag, "_req"},    {15'd0, imem_req},    {15'd0, req});
      check({tag, "_addr"},   imem_addr,            addr);
      check({tag, "_valid"},  {15'd0, instr_valid}, {15'd0, valid});
      check({tag, "_instr"},  instr,                ins);
      check({tag, "_pp2"},    pc_plus2,             pp2);
      check({tag, "_halted"}, {15'd0, halted},      {15'd0, hlt});
      check({tag, "_err"},    {15'd0, err},         {15'd0, er});
   endtask

   task automatic drive(input logic rd, input logic [15:0] rpc, input logic rdy,
                        input logic [15:0] data, input logic rdy_dec);
      redirect    = rd;
      redirect_pc = rpc;
      imem_rdy    = rdy;
      imem_data   = data;
      instr_ready = rdy_dec;
   endtask

   task automatic add(input logic rd, input logic [15:0] rpc, input logic rdy, input logic [15:0] data,
                      input logic rdy_dec, input logic req, input logic [15:0] addr, input logic valid,
                      input logic [15:0] ins, input logic [15:0] pp2, input logic hlt, input logic er);
      vec_t v;
      v.redirect = rd; v.redirect_pc = rpc; v.imem_rdy = rdy; v.imem_data = data;
      v.instr_ready = rdy_dec; v.e_req = req; v.e_addr = addr; v.e_valid = valid;
      v.e_instr = ins; v.e_pp2 = pp2; v.e_halted = hlt; v.e_err = er;
      vecs.push_back(v);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

      //   rd  rpc       rdy data      dec   req addr      vld instr     pp2       hlt err
      // zero-wait memory, decode always ready
      add(0, 16'h0000, 1, 16'h4001, 1,    0, 16'h0000, 1, 16'h4001, 16'h0002, 0, 0);
      add(0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0002, 0, 16'h4001, 16'h0002, 0, 0);
      add(0, 16'h0000, 1, 16'h4102, 1,    0, 16'h0002, 1, 16'h4102, 16'h0004, 0, 0);
      add(0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0004, 0, 16'h4102, 16'h0004, 0, 0);
      // three wait cycles on memory, then decode stalls four cycles
      add(0, 16'h0000, 0, 16'hdead, 0,    1, 16'h0004, 0, 16'h4102, 16'h0004, 0, 0);
      add(0, 16'h0000, 0, 16'hdead, 0,    1, 16'h0004, 0, 16'h4102, 16'h0004, 0, 0);
      add(0, 16'h0000, 0, 16'hdead, 0,    1, 16'h0004, 0, 16'h4102, 16'h0004, 0, 0);
      add(0, 16'h0000, 1, 16'h4203, 0,    0, 16'h0004, 1, 16'h4203, 16'h0006, 0, 0);
      add(0, 16'h0000, 1, 16'h5555, 0,    0, 16'h0004, 1, 16'h4203, 16'h0006, 0, 0);
      add(0, 16'h0000, 0, 16'h0000, 0,    0, 16'h0004, 1, 16'h4203, 16'h0006, 0, 0);
      add(0, 16'h0000, 1, 16'h6666, 0,    0, 16'h0004, 1, 16'h4203, 16'h0006, 0, 0);
      add(0, 16'h0000, 0, 16'h0000, 0,    0, 16'h0004, 1, 16'h4203, 16'h0006, 0, 0);
      add(0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0006, 0, 16'h4203, 16'h0006, 0, 0);
      // redirect in FETCH discards same-cycle memory data
      add(1, 16'h0010, 1, 16'h1234, 0,    1, 16'h0010, 0, 16'h4203, 16'h0006, 0, 0);
      add(0, 16'h0000, 1, 16'h4444, 0,    0, 16'h0010, 1, 16'h4444, 16'h0012, 0, 0);
      // redirect in VALID with decode accepting: instruction dropped, no pc+2
      add(1, 16'h0100, 0, 16'h0000, 1,    1, 16'h0100, 0, 16'h4444, 16'h0012, 0, 0);
      // wrap-around at 0xFFFE
      add(1, 16'hfffe, 0, 16'h0000, 0,    1, 16'hfffe, 0, 16'h4444, 16'h0012, 0, 0);
      add(0, 16'h0000, 1, 16'h4001, 0,    0, 16'hfffe, 1, 16'h4001, 16'h0000, 0, 0);
      add(0, 16'h0000, 0, 16'h0000, 1,    1, 16'h0000, 0, 16'h4001, 16'h0000, 0, 0);
      // HALT at 0x0006
      add(1, 16'h0006, 0, 16'h0000, 0,    1, 16'h0006, 0, 16'h4001, 16'h0000, 0, 0);
      add(0, 16'h0000, 1, 16'h0000, 0,    0, 16'h0006, 1, 16'h0000, 16'h0008, 0, 0);
      add(0, 16'h0000, 0, 16'h0000, 1,    0, 16'h0006, 0, 16'h0000, 16'h0008, 1, 0);
      add(1, 16'h0020, 1, 16'h4001, 1,    0, 16'h0006, 0, 16'h0000, 16'h0008, 1, 0);
      add(0, 16'h0000, 1, 16'h4001, 1,    0, 16'h0006, 0, 16'h0000, 16'h0008, 1, 0);

      // reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check_outs("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_outs("first_req", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].redirect, vecs[i].redirect_pc, vecs[i].imem_rdy, vecs[i].imem_data,
               vecs[i].instr_ready);
         @(posedge clk);
         #1;
         check_outs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_pp2, vecs[i].e_halted, vecs[i].e_err);
      end

      // asynchronous reset clears halted immediately
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_outs("async_rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // misaligned redirect -> ERROR, sticky, inputs ignored
      drive(1'b1, 16'h0101, 1'b0, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      check_outs("err_set", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      drive(1'b1, 16'h0040, 1'b1, 16'h4001, 1'b1);
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0000, 1'b1, 16'h4001, 1'b1);
      @(posedge clk);
      #1;
      check_outs("err_hold", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

      // reset pulse clears err; a response held during reset is dropped
      rst = 1'b0;
      #1;
      check_outs("err_clr", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
      @(posedge clk);
      #1;
      check_outs("restart", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      drive(1'b0, 16'h0000, 1'b1, 16'h4abc, 1'b1);
      @(posedge clk);
      #1;
      check_outs("restart_fetch", 1'b0, 16'h0000, 1'b1, 16'h4abc, 16'h0002, 1'b0, 1'b0);

      // reset mid-handshake drops the presented instruction
      rst = 1'b0;
      #1;
      check_outs("mid_rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      check_outs("post_mid_rst", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
